button_event: RTL and testbench

BUTTON_EVENT -- requirements
Module: button_event

---
 rtl/button_pkg.sv | 18 +
 rtl/edge_detect.sv | 31 +++
 rtl/button_event.sv | 147 ++++++++++++++
 tb/tb_button_event.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the button event stage.
// Holds the FSM state encoding and the default hold/repeat tick constants
// so that every file of the block agrees on them.
package button_pkg;

    // Button FSM states; the encoding is fixed so debug views stay stable.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } btn_state_t;

    // 0.5 s hold before LONG and 0.1 s repeat period at 100 MHz.
    localparam int unsigned DEF_LONG_TICKS   = 32'd50000000;
    localparam int unsigned DEF_REPEAT_TICKS = 32'd10000000;
    localparam int unsigned DEF_CNT_W        = 32'd27;

endpackage

// File: rtl/edge_detect.sv
// Rising/falling edge detector for an already-synchronised level.
// Ports:
//   CLK   - clock, all state on rising edge
//   RST_N - synchronous active-low reset (clears the delayed copy to 0)
//   din   - input level
//   rise  - din high now, low on the previous edge (combinational)
//   fall  - din low now, high on the previous edge (combinational)
module edge_detect (
    input  logic CLK,
    input  logic RST_N,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic dq_r;

    // Delayed copy of the input level; resets low so a level already high
    // after reset is seen as a fresh rising edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dq_r <= 1'b0;
        end else begin
            dq_r <= din;
        end
    end

    assign rise = din & ~dq_r;
    assign fall = ~din & dq_r;

endmodule

// File: rtl/button_event.sv
// Button event generator: turns a debounced button level into PRESS,
// RELEASE, LONG (hold reached LONG_TICKS) and RPT (auto-repeat every
// REPEAT_TICKS after LONG) pulses, plus a HELD level.
// Ports:
//   CLK     - system clock
//   RST_N   - synchronous active-low reset
//   DBTN    - debounced, synchronised button level
//   PRESS   - one-cycle pulse on press
//   RELEASE - one-cycle pulse on release
//   LONG    - one-cycle pulse when the hold reaches LONG_TICKS
//   RPT     - one-cycle auto-repeat pulse
//   HELD    - high while the button is considered held
// All outputs are registered.
module button_event
    import button_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic DBTN,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG,
    output logic RPT,
    output logic HELD
);

    // Terminal counts: the counter starts at 0 on entry, so the last value
    // before the pulse is TICKS-1.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 32'd1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 32'd1);

    logic             rise_s;
    logic             fall_s;

    btn_state_t       state_r;
    btn_state_t       state_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             press_r;
    logic             press_s;
    logic             release_r;
    logic             release_s;
    logic             long_r;
    logic             long_s;
    logic             rpt_r;
    logic             rpt_s;
    logic             held_r;
    logic             held_s;

    edge_detect u_edge (
        .CLK   (CLK),
        .RST_N (RST_N),
        .din   (DBTN),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Next-state, hold counter and output pulse decode. A fall is checked
    // before the terminal count so a release never coincides with LONG/RPT.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        long_s    = 1'b0;
        rpt_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_s = ST_PRESSED;
                    count_s = '0;
                    press_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    count_s = '0;
                end
            end
            ST_PRESSED: begin
                if (fall_s) begin
                    state_s   = ST_IDLE;
                    count_s   = '0;
                    release_s = 1'b1;
                end else if (count_r == LONG_LAST) begin
                    state_s = ST_REPEAT;
                    count_s = '0;
                    long_s  = 1'b1;
                end else begin
                    count_s = count_r + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (fall_s) begin
                    state_s   = ST_IDLE;
                    count_s   = '0;
                    release_s = 1'b1;
                end else if (count_r == REPEAT_LAST) begin
                    state_s = ST_REPEAT;
                    count_s = '0;
                    rpt_s   = 1'b1;
                end else begin
                    count_s = count_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                count_s = '0;
            end
        endcase

        // HELD follows the state being entered, so it rises with PRESS and
        // drops in the RELEASE cycle.
        held_s = (state_s == ST_PRESSED) || (state_s == ST_REPEAT);
    end

    // State, counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r   <= ST_IDLE;
            count_r   <= '0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
            rpt_r     <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            press_r   <= press_s;
            release_r <= release_s;
            long_r    <= long_s;
            rpt_r     <= rpt_s;
            held_r    <= held_s;
        end
    end

    assign PRESS   = press_r;
    assign RELEASE = release_r;
    assign LONG    = long_r;
    assign RPT     = rpt_r;
    assign HELD    = held_r;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event with LONG_TICKS=8, REPEAT_TICKS=4.
// Cycle k is the clock period whose outputs appear after the k-th edge of
// a scenario; DBTN level for cycle c is applied before the edge ending c.
module tb_button_event;

    localparam int L = 8;
    localparam int R = 4;

    logic CLK = 1'b0;
    logic RST_N;
    logic DBTN;
    logic PRESS;
    logic RELEASE;
    logic LONG;
    logic RPT;
    logic HELD;

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];

    always #5 CLK = ~CLK;

    button_event #(
        .LONG_TICKS   (L),
        .REPEAT_TICKS (R),
        .CNT_W        (27)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .DBTN    (DBTN),
        .PRESS   (PRESS),
        .RELEASE (RELEASE),
        .LONG    (LONG),
        .RPT     (RPT),
        .HELD    (HELD)
    );

    // Expected {PRESS,RELEASE,LONG,RPT,HELD} in cycle k for a hold whose
    // PRESS lands in cycle p and whose first low DBTN cycle is h.
    function automatic logic [4:0] exp_at(int k, int p, int h, bit rel);
        logic pr, rl, lg, rp, hd;
        pr = (k == p);
        hd = (k >= p) && (k <= h);
        rl = rel && (k == h + 1);
        lg = (k == p + L) && (k <= h);
        rp = (k > p + L) && (((k - p - L) % R) == 0) && (k <= h);
        return {pr, rl, lg, rp, hd};
    endfunction

    // Drive one cycle of stimulus, queue what the next cycle must show,
    // then move to just after the edge.
    task automatic step(input logic d, input logic r, input logic [4:0] e);
        @(negedge CLK);
        DBTN  = d;
        RST_N = r;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] got, want;
        for (int c = 0; c < 8; c++) begin
            step(c < 4, c >= 2, (c + 1 <= 2) ? 5'b00000 : exp_at(c + 1, 3, 4, 1'b1));
            got  = {PRESS, RELEASE, LONG, RPT, HELD};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset cycle %0d got %b expected %b (press,release,long,rpt,held)",
                         c + 1, got, want);
            end
        end
    endtask

    task automatic test_hold(input string name, input int h);
        logic [4:0] got, want;
        for (int c = 0; c < h + 4; c++) begin
            step(c < h, 1'b1, exp_at(c + 1, 1, h, 1'b1));
            got  = {PRESS, RELEASE, LONG, RPT, HELD};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s cycle %0d got %b expected %b (press,release,long,rpt,held)",
                         name, c + 1, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] got, want, e;
        int k;
        for (int c = 0; c < 14; c++) begin
            k = c + 1;
            if (k <= 5)      e = exp_at(k, 1, 5, 1'b0);
            else if (k == 6) e = 5'b00000;
            else             e = exp_at(k, 7, 9, 1'b1);
            step(c < 9, c != 5, e);
            got  = {PRESS, RELEASE, LONG, RPT, HELD};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_hold cycle %0d got %b expected %b (press,release,long,rpt,held)",
                         k, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got, want;
        for (int c = 0; c < 10; c++) begin
            step((c < 3) || (c == 4) || (c == 5), 1'b1,
                 exp_at(c + 1, 1, 3, 1'b1) | exp_at(c + 1, 5, 6, 1'b1));
            got  = {PRESS, RELEASE, LONG, RPT, HELD};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back cycle %0d got %b expected %b (press,release,long,rpt,held)",
                         c + 1, got, want);
            end
        end
    endtask

    initial begin
        RST_N = 1'b0;
        DBTN  = 1'b0;
        test_reset();
        test_hold("short_press", 3);
        test_hold("long_repeat", 20);
        test_hold("release_at_long_tc", 8);
        test_hold("long_then_release", 9);
        test_hold("release_at_rpt_tc", 12);
        test_hold("glitch", 1);
        test_reset_mid_hold();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
